// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
// Array contents are never reset; only the read register is.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read-before-write on a shared address: the old word is returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with thresholds, sticky error flags,
// synchronous flush and a registered read port with valid strobe.
module sync_fifo_param import fifo_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      wr,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      rd,
    output logic [DATA_W-1:0]         data_out,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   fifo_cnt,
    output logic                      overflow,
    output logic                      underflow
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $fatal(1, "sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
            $fatal(1, "sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
        end
    endgenerate

    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rd_valid, r_overflow, r_underflow;
    logic             w_wr_acc, w_rd_acc;

    // A read frees a slot in the same edge, so a write at full may proceed.
    assign w_wr_acc = wr & (~full | rd);
    assign w_rd_acc = rd & ~empty;

    fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_wr_acc & ~flush),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_re    (w_rd_acc & ~flush),
        .i_raddr (r_rd_ptr),
        .o_rdata (data_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
            r_rd_valid <= w_rd_acc;
            if (wr && full && !rd) r_overflow  <= 1'b1;
            if (rd && empty)       r_underflow <= 1'b1;
        end
    end

    assign fifo_cnt     = r_cnt;
    assign rd_valid     = r_rd_valid;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign full         = (r_cnt == CNT_W'(DEPTH));
    assign empty        = (r_cnt == '0);
    assign almost_full  = (r_cnt >= CNT_W'(AF_LEVEL));
    assign almost_empty = (r_cnt <= CNT_W'(AE_LEVEL));
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param with a read-data scoreboard.
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] data_in = '0;
    logic       rd = 1'b0;
    logic [7:0] data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty;
    logic [3:0] fifo_cnt;
    logic       overflow, underflow;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr(wr), .data_in(data_in),
        .rd(rd), .data_out(data_out), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .fifo_cnt(fifo_cnt), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rd_valid: got data 0x%0h expected no read at %0t", data_out, $time);
            end else begin
                chk("rd_data", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r);
        @(negedge clk);
        wr = w; data_in = d; rd = r;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic chk_flags(input string nm, input int cnt);
        chk({nm, "_cnt"},   int'(fifo_cnt),     cnt);
        chk({nm, "_full"},  int'(full),         int'(cnt == 8));
        chk({nm, "_empty"}, int'(empty),        int'(cnt == 0));
        chk({nm, "_af"},    int'(almost_full),  int'(cnt >= 6));
        chk({nm, "_ae"},    int'(almost_empty), int'(cnt <= 2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk_flags("reset", 0);
        chk("reset_ovf", int'(overflow), 0);
        chk("reset_unf", int'(underflow), 0);
        chk("reset_rdv", int'(rd_valid), 0);
        chk("reset_dout", int'(data_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fill 0x01..0x08 then drain in order
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0);
            chk_flags("fill", i);
        end
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(8'(i));
            step(1'b0, 8'h00, 1'b1);
            chk_flags("drain", 8 - i);
            chk("drain_rdv", int'(rd_valid), 1);
        end
        step(1'b0, 8'h00, 1'b0);
        chk("idle_rdv", int'(rd_valid), 0);

        // overflow then simultaneous wr+rd at full
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h09, 1'b0);
        chk_flags("ovf", 8);
        chk("ovf_flag", int'(overflow), 1);
        exp_q.push_back(8'h01);
        step(1'b1, 8'h0A, 1'b1);
        chk_flags("full_rw", 8);
        chk("full_rw_ovf_sticky", int'(overflow), 1);
        for (int i = 2; i <= 8; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h0A);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        chk_flags("drain2", 0);

        // read at empty with a concurrent write
        step(1'b1, 8'h55, 1'b1);
        chk("unf_flag", int'(underflow), 1);
        chk("unf_rdv", int'(rd_valid), 0);
        chk("unf_dout_hold", int'(data_out), 8'h0A);
        chk_flags("unf", 1);
        exp_q.push_back(8'h55);
        step(1'b0, 8'h00, 1'b1);
        chk_flags("unf_read", 0);

        // pointer wrap with constant occupancy 3
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            step(1'b1, 8'(8'h13 + i), 1'b1);
            chk("wrap_cnt", int'(fifo_cnt), 3);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'(8'h24 + i));
            step(1'b0, 8'h00, 1'b1);
        end
        chk_flags("wrap_end", 0);

        // flush at count 5 with overflow set; requests that cycle discarded
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'(8'h30 + i));
            step(1'b0, 8'h00, 1'b1);
        end
        chk_flags("pre_flush", 5);
        chk("pre_flush_ovf", int'(overflow), 1);
        @(negedge clk);
        flush = 1'b1; wr = 1'b1; data_in = 8'h77; rd = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; wr = 1'b0; rd = 1'b0;
        chk_flags("flush", 0);
        chk("flush_ovf", int'(overflow), 0);
        chk("flush_unf", int'(underflow), 0);
        chk("flush_rdv", int'(rd_valid), 0);
        chk("flush_dout_hold", int'(data_out), 8'h32);

        // async reset mid-burst, before the next clock edge
        step(1'b1, 8'h40, 1'b0);
        exp_q.push_back(8'h40);
        step(1'b1, 8'h41, 1'b1);
        chk("pre_rst_rdv", int'(rd_valid), 1);
        @(negedge clk);
        wr = 1'b1; data_in = 8'h42; rd = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_flags("async_rst", 0);
        chk("async_rst_rdv", int'(rd_valid), 0);
        chk("async_rst_dout", int'(data_out), 0);
        wr = 1'b0; rd = 1'b0;
        @(posedge clk);
        #1;
        chk_flags("rst_held", 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("scoreboard_leftover", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO, the next-generation replacement for the fixed 8x8 FIFO in the buffering library. Generic data width and power-of-two depth, correct simultaneous read/write at full and empty, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a registered read port with a valid strobe. Sits between any producer/consumer pair sharing one clock.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of pointers, count and error flags
- wr  in  1  write request
- data_in  in  DATA_W  write data, sampled with wr
- rd  in  1  read request
- data_out  out  DATA_W  registered read data
- rd_valid  out  1  data_out holds a newly read word this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- fifo_cnt  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty

## Operation
- Reset (rst_n low, async): pointers 0, fifo_cnt 0, data_out 0, rd_valid 0, overflow 0, underflow 0; hence empty 1, full 0, almost_empty 1, almost_full 0. Memory contents not reset.
- wr_acc = wr & (!full | rd); rd_acc = rd & !empty. All decisions use registered state at the edge.
- Write at full with no read: dropped, overflow set. Write at full with read: both accepted, count unchanged, pointers both advance.
- Read at empty: ignored (even if wr high; write still accepted), underflow set, rd_valid 0, data_out holds.
- Count: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither. Never exceeds DEPTH or goes below 0.
- Pointers are $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
- flush: synchronous, highest priority over wr/rd that cycle; pointers/count/error flags to 0, rd_valid 0, data_out holds, requests that cycle are discarded.
- overflow/underflow clear only on reset or flush.
- All flags are combinational decodes of registered fifo_cnt (no extra latency beyond count).

## Timing
- Write latency: word written at edge N is readable (empty deasserted) from cycle N+1.
- Read latency 1: rd accepted at edge N → data_out valid and rd_valid=1 after edge N (one cycle pulse per accepted read).
- Back-to-back: one read and one write per cycle sustained indefinitely; throughput 1 word/cycle.
- fifo_cnt and all flags reflect the edge's accepted operations immediately after that edge.
- Reset assertion mid-operation takes effect immediately, without waiting for clk; deassertion is assumed synchronised upstream.

## Structure
- fifo_pkg: shared count-width helper ($clog2(DEPTH)+1) and default parameter constants, reused by future FIFO variants.
- Sub-module fifo_mem: simple dual-port RAM (one write port, one registered read port), DEPTH x DATA_W, no reset. Top holds pointers, counter, flags and error logic.
- Elaboration check: DEPTH not power of two or AF/AE out of range → fatal error.

## Test plan
- Reset, DATA_W=8 DEPTH=8: after rst_n low, empty=1, full=0, fifo_cnt=0, almost_empty=1, overflow=underflow=0.
- Write 0x01..0x08, then read 8: full=1 after 8th write, almost_full from count 6; reads return 0x01..0x08 in order, each one cycle after rd with rd_valid pulses, empty=1 at end.
- Full + 9th write alone → 0x09 dropped, overflow=1, count 8; then wr+rd together at full → count stays 8, read returns 0x01, 0x0A enters.
- Empty + rd+wr together with 0x55 → underflow=1, count=1, rd_valid=0; next cycle rd returns 0x55.
- Wrap: 20 cycles of continuous simultaneous wr/rd after prefill of 3 → data order preserved across pointer wrap, count constant 3.
- flush with count 5 and overflow set → next cycle count 0, empty=1, overflow=0; rst_n pulsed mid-burst → outputs at reset values before next clk edge.
